// File: rtl/ast_if.sv
// Avalon-ST source/sink bundle carrying one sample per transfer plus a 2-bit error tag.
// A transfer happens only in a cycle with valid = 1 and ready = 1; ready may toggle freely.
interface ast_if #(
   parameter int DATA_W = 8
) ();
   logic [DATA_W-1:0] data;
   logic              valid;
   logic              ready;
   logic [1:0]        error;

   modport master (output data, output valid, output error, input ready);
   modport slave  (input data, input valid, input error, output ready);
endinterface

// File: rtl/ast_sample_source.sv
// Buffers a free-running, never-stalled sample stream in a small first-word-fall-through FIFO
// and presents it on an Avalon-ST source (readyLatency 0), tagging samples that follow a loss.
module ast_sample_source #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              sclk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   input  logic              flush,
   ast_if.master             ast_source,
   output logic [ADDR_W:0]   fifo_level,
   output logic [15:0]       drop_cnt
);
   localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

   // Each entry is {error tag, sample}.
   logic [DATA_W:0]   mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count;
   logic              lost_flag;
   logic              valid;
   logic              full;
   logic              pop;
   logic              push;
   logic              drop;
   logic [DATA_W:0]   head;

   assign valid = (count != '0);
   assign full  = (count == FULL_COUNT);
   assign pop   = valid & ast_source.ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign push  = in_valid & ~flush & (~full | pop);
   assign drop  = in_valid & ~flush & full & ~pop;
   assign head  = mem[rd_ptr];

   assign ast_source.valid = valid;
   assign ast_source.data  = head[DATA_W-1:0];
   assign ast_source.error = {1'b0, valid & head[DATA_W]};
   assign fifo_level       = count;

   always_ff @(posedge sclk) begin
      if (push) begin
         mem[wr_ptr] <= {lost_flag, in_data};
      end
   end

   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         lost_flag <= 1'b0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         lost_flag <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr    <= wr_ptr + PTR_ONE;
            lost_flag <= 1'b0;
         end else if (drop) begin
            lost_flag <= 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (push && !pop) begin
            count <= count + CNT_ONE;
         end else if (pop && !push) begin
            count <= count - CNT_ONE;
         end
      end
   end

   // Drop count survives flush; only reset clears it.
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= '0;
      end else if (drop && drop_cnt != 16'hFFFF) begin
         drop_cnt <= drop_cnt + 16'd1;
      end
   end
endmodule

// File: doc/ast_sample_source.md
# ast_sample_source

Avalon-ST transmitter that feeds the FIR low-pass filter's sink port from a free-running sample producer such as the 1 MHz/10 MHz DDS. It buffers producer samples in a small first-word-fall-through FIFO and presents them with a correct valid/ready handshake (readyLatency = 0). When the FIR deasserts `ast_sink_ready`, this block absorbs the samples; it drops and flags them only on overflow. It sits between the DDS output and the FIR `ast_sink_*` ports in the filter top level.

## Interface
- `DATA_W`, 8, sample width; matches the DDS `o_wave` and the FIR sink data.
- `DEPTH`, 8, FIFO entries; must be a power of two, at least 2.
- `ADDR_W`, 3, log2(DEPTH).
- `sclk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  DATA_W  producer sample.
- `in_valid`  in  1  producer strobe; one sample per high cycle; never back-pressured.
- `flush`  in  1  synchronous FIFO clear.
- `ast_source_data`  out  DATA_W  sample to the FIR `ast_sink_data`.
- `ast_source_valid`  out  1  to the FIR `ast_sink_valid`.
- `ast_source_ready`  in  1  from the FIR `ast_sink_ready`.
- `ast_source_error`  out  2  to the FIR `ast_sink_error`; bit0 = samples lost before this one; bit1 = 0.
- `fifo_level`  out  ADDR_W+1  current occupancy, 0..DEPTH.
- `drop_cnt`  out  16  dropped-sample count; saturates at 16'hFFFF.

## Operation
- **Storage**
  - DEPTH × (DATA_W+1) register array; the extra bit is the error tag.
  - Write pointer `wr_ptr`, read pointer `rd_ptr` (ADDR_W bits, natural wrap), occupancy `count` (ADDR_W+1 bits).
- **Push and pop**
  - push = `in_valid` & (count < DEPTH | pop).
  - pop = `ast_source_valid` & `ast_source_ready`.
- **Output**
  - `ast_source_valid` = (count != 0).
  - `ast_source_data` and error bit0 come from `mem[rd_ptr]`: first-word-fall-through, combinational from registers.
  - `ast_source_error[1]` is tied to 0.
- **Data stability**
  - While valid is high and ready is low, data and error hold unchanged.
  - Valid never drops without a pop or a flush.
- **Full and simultaneous pop**
  - On a full FIFO with a simultaneous pop, the push is accepted and count stays at DEPTH.
- **Overflow**
  - `in_valid` while full with no pop drops the sample and sets `lost_flag`.
  - `drop_cnt` increments by 1, saturating.
  - The next accepted push stores tag = 1 and clears `lost_flag` in the same cycle.
  - All other pushes store tag = 0.
- **Empty with push**
  - Push into an empty FIFO: valid rises the next cycle. There is no bypass.
- **Flush**
  - `flush` = 1: next edge sets `wr_ptr` = `rd_ptr` = `count` = 0 and clears `lost_flag`.
  - A same-cycle push is discarded and not counted as a drop.
  - A same-cycle pop still completes on the bus, since valid was high.
  - `drop_cnt` is not cleared by flush.
- **Level**
  - `fifo_level` = `count`, registered.

## Timing
- Reset (async assert, sync release by the top level):
  - pointers, `count`, `lost_flag`, `drop_cnt` all 0;
  - `ast_source_valid` = 0, `fifo_level` = 0, `ast_source_error` = 0;
  - `ast_source_data` is don't-care while valid is 0.
- Latency: `in_valid` at edge N (empty FIFO, ready held high) gives valid/data at N+1. With ready high, the pop occurs at N+1 and valid falls at N+2 unless another push arrives.
- Throughput: 1 sample per cycle sustained while ready is high.
- Handshake: transfer occurs only in a cycle with valid = 1 and ready = 1 (readyLatency 0). Ready may toggle freely.
- Reset mid-operation: contents are lost; valid falls asynchronously.

## Test plan
- **Pass-through:** ready = 1, `in_valid` = 1 every cycle, data 0,1,2,… → identical sequence on the output, 1-cycle latency, `fifo_level` ≤ 1, `drop_cnt` = 0.
- **Back-pressure:** ready = 0, push 5 samples (A0..A4) → valid high with data A0 stable, `fifo_level` = 5. Raise ready → A0..A4 on 5 consecutive cycles, then valid = 0.
- **Overflow:** ready = 0, push 10 samples 0..9 (DEPTH 8) → `drop_cnt` = 2, samples 8 and 9 lost. Push 10 → it is stored with error = 2'b01 only if a slot is free; drain to check. Outputs 0..7 error 0; 10 (pushed after draining 1) has error = 2'b01.
- **Full with pop and push:** full, ready = 1, `in_valid` = 1 → `fifo_level` stays 8, no drop, FIFO order preserved across pointer wrap.
- **Flush:** 4 queued, flush with simultaneous `in_valid` → next cycle valid = 0, `fifo_level` = 0, `drop_cnt` unchanged.
- **Async reset mid-stream:** `rst_n` low with 6 queued → valid = 0 immediately. After release, the first push appears after 1 cycle with error 0.
